// File: rtl/sc_operand_sequencer_if.sv
// Operand-sequencer bus: sweep control, operand-memory read ports and the
// operand pair presented to the SNG bank.
// master = sequencer side, slave = core / memory / controller side.
interface sc_operand_sequencer_if #(
  parameter int BATCH_SIZE       = 4,
  parameter int INPUT_FEATURES   = 4,
  parameter int OUTPUT_FEATURES  = 4,
  parameter int BINARY_PRECISION = 8
);
  localparam int ROW_W = BINARY_PRECISION * INPUT_FEATURES;
  localparam int M_W   = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
  localparam int O_W   = (OUTPUT_FEATURES > 1) ? $clog2(OUTPUT_FEATURES) : 1;

  logic             start;
  logic             busy;
  logic             done;
  logic             in_rd_en;
  logic [M_W-1:0]   in_rd_addr;
  logic [ROW_W-1:0] in_rd_data;
  logic             w_rd_en;
  logic [O_W-1:0]   w_rd_addr;
  logic [ROW_W-1:0] w_rd_data;
  logic [ROW_W-1:0] input_data;
  logic [ROW_W-1:0] weight_data;
  logic             operand_valid;
  logic             last;
  logic [M_W-1:0]   out_row;
  logic [O_W-1:0]   out_col;

  modport master (
    input  start, in_rd_data, w_rd_data,
    output busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
           input_data, weight_data, operand_valid, last, out_row, out_col
  );

  modport slave (
    output start, in_rd_data, w_rd_data,
    input  busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr,
           input_data, weight_data, operand_valid, last, out_row, out_col
  );
endinterface

// File: rtl/sc_operand_sequencer.sv
// Operand sequencer for the stochastic matrix-multiply core.
// Sweeps every (m, o) pair, o inner / m outer, holding each pair on
// input_data/weight_data for one conversion window and flagging the final
// window cycle with last.
// Optional build macro SC_OPERAND_PREFETCH_EN: the next pair is read during
// the tail of the current window so STREAM runs back-to-back.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | read strobes out for row m / row o
// LOAD   | memory data captured into the operand registers
// STREAM | pair presented to the SNGs, cnt counts the window
// DONE   | one-cycle end-of-sweep pulse
module sc_operand_sequencer #(
  parameter int BATCH_SIZE        = 4,
  parameter int INPUT_FEATURES    = 4,
  parameter int OUTPUT_FEATURES   = 4,
  parameter int BINARY_PRECISION  = 8,
  parameter int STOCHASTIC_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  sc_operand_sequencer_if.master bus
);
  localparam int ROW_W  = BINARY_PRECISION * INPUT_FEATURES;
  localparam int M_W    = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
  localparam int O_W    = (OUTPUT_FEATURES > 1) ? $clog2(OUTPUT_FEATURES) : 1;
  localparam int WINDOW = STOCHASTIC_CYCLES * (2 ** BINARY_PRECISION);
  localparam int CNT_W  = $clog2(WINDOW) + 1;

  localparam logic [M_W-1:0]   M_LAST   = M_W'(BATCH_SIZE - 1);
  localparam logic [O_W-1:0]   O_LAST   = O_W'(OUTPUT_FEATURES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
`ifdef SC_OPERAND_PREFETCH_EN
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WINDOW - 2);
`endif

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t           state, state_nx;
  logic [M_W-1:0]   m, m_nx;
  logic [O_W-1:0]   o, o_nx;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] input_q, weight_q;
  logic [M_W-1:0]   row_q;
  logic [O_W-1:0]   col_q;
  logic             win_end, last_pair;

  assign win_end   = (state == S_STREAM) && (cnt == CNT_LAST);
  assign last_pair = (m == M_LAST) && (o == O_LAST);

  // Indices of the pair that follows (m, o); o is the inner loop.
  always_comb begin
    m_nx = m;
    o_nx = o + O_W'(1);
    if (o == O_LAST) begin
      o_nx = '0;
      m_nx = m + M_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_LOAD;
      S_LOAD:   state_nx = S_STREAM;
      S_STREAM: begin
        if (win_end) begin
`ifdef SC_OPERAND_PREFETCH_EN
          state_nx = last_pair ? S_DONE : S_STREAM;
`else
          state_nx = last_pair ? S_DONE : S_FETCH;
`endif
        end
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Sweep indices, window counter and the registered operand pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      m        <= '0;
      o        <= '0;
      cnt      <= '0;
      input_q  <= '0;
      weight_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            m <= '0;
            o <= '0;
          end
        end
        S_LOAD: begin
          input_q  <= bus.in_rd_data;
          weight_q <= bus.w_rd_data;
          row_q    <= m;
          col_q    <= o;
          cnt      <= '0;
        end
        S_STREAM: begin
          cnt <= cnt + CNT_W'(1);
          if (win_end && !last_pair) begin
            m <= m_nx;
            o <= o_nx;
`ifdef SC_OPERAND_PREFETCH_EN
            // Prefetched rows arrive on the last window cycle; the operand
            // registers take them directly as the shadow stage so the
            // switch lands on the cycle after last.
            input_q  <= bus.in_rd_data;
            weight_q <= bus.w_rd_data;
            row_q    <= m_nx;
            col_q    <= o_nx;
            cnt      <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded outputs: status, read strobes and window flags.
  always_comb begin
    bus.busy          = (state != S_IDLE);
    bus.done          = (state == S_DONE);
    bus.in_rd_en      = 1'b0;
    bus.w_rd_en       = 1'b0;
    bus.in_rd_addr    = '0;
    bus.w_rd_addr     = '0;
    bus.operand_valid = 1'b0;
    bus.last          = 1'b0;
    case (state)
      S_FETCH: begin
        bus.in_rd_en   = 1'b1;
        bus.w_rd_en    = 1'b1;
        bus.in_rd_addr = m;
        bus.w_rd_addr  = o;
      end
      S_STREAM: begin
        bus.operand_valid = 1'b1;
        bus.last          = (cnt == CNT_LAST);
`ifdef SC_OPERAND_PREFETCH_EN
        if ((cnt == CNT_PRE) && !last_pair) begin
          bus.in_rd_en   = 1'b1;
          bus.w_rd_en    = 1'b1;
          bus.in_rd_addr = m_nx;
          bus.w_rd_addr  = o_nx;
        end
`endif
      end
      default: ;
    endcase
  end

  assign bus.input_data  = input_q;
  assign bus.weight_data = weight_q;
  assign bus.out_row     = row_q;
  assign bus.out_col     = col_q;
endmodule

// File: tb/tb_sc_operand_sequencer.sv
// Bench for sc_operand_sequencer: three instances (1x1 P=2, defaults, 2x2 P=2),
// each with a one-cycle-latency operand memory. Expected pairs are queued
// when start is driven and popped as each new pair appears on the outputs.
module tb_sc_operand_sequencer;
`ifdef SC_OPERAND_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b, rst_c;
  int   errors = 0;
  int   checks = 0;
  int   sel = 0;

  sc_operand_sequencer_if #(.BATCH_SIZE(1), .INPUT_FEATURES(4), .OUTPUT_FEATURES(1),
                            .BINARY_PRECISION(2)) if_a ();
  sc_operand_sequencer_if #(.BATCH_SIZE(4), .INPUT_FEATURES(4), .OUTPUT_FEATURES(4),
                            .BINARY_PRECISION(8)) if_b ();
  sc_operand_sequencer_if #(.BATCH_SIZE(2), .INPUT_FEATURES(4), .OUTPUT_FEATURES(2),
                            .BINARY_PRECISION(2)) if_c ();

  sc_operand_sequencer #(.BATCH_SIZE(1), .INPUT_FEATURES(4), .OUTPUT_FEATURES(1),
                         .BINARY_PRECISION(2), .STOCHASTIC_CYCLES(1))
    dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
  sc_operand_sequencer #(.BATCH_SIZE(4), .INPUT_FEATURES(4), .OUTPUT_FEATURES(4),
                         .BINARY_PRECISION(8), .STOCHASTIC_CYCLES(1))
    dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
  sc_operand_sequencer #(.BATCH_SIZE(2), .INPUT_FEATURES(4), .OUTPUT_FEATURES(2),
                         .BINARY_PRECISION(2), .STOCHASTIC_CYCLES(1))
    dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

  // Memory contents per instance.
  function automatic logic [31:0] exp_in(input int d, input int r);
    case (d)
      0:       return 32'hA5;
      1:       return 32'(r);
      default: return 32'h10 + 32'(r);
    endcase
  endfunction

  function automatic logic [31:0] exp_w(input int d, input int c);
    case (d)
      0:       return 32'h3C;
      1:       return 32'(c);
      default: return 32'h20 + 32'(c);
    endcase
  endfunction

  // Operand memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (if_a.in_rd_en) if_a.in_rd_data <= 8'(exp_in(0, int'(if_a.in_rd_addr)));
    if (if_a.w_rd_en)  if_a.w_rd_data  <= 8'(exp_w(0, int'(if_a.w_rd_addr)));
    if (if_b.in_rd_en) if_b.in_rd_data <= exp_in(1, int'(if_b.in_rd_addr));
    if (if_b.w_rd_en)  if_b.w_rd_data  <= exp_w(1, int'(if_b.w_rd_addr));
    if (if_c.in_rd_en) if_c.in_rd_data <= 8'(exp_in(2, int'(if_c.in_rd_addr)));
    if (if_c.w_rd_en)  if_c.w_rd_data  <= 8'(exp_w(2, int'(if_c.w_rd_addr)));
  end

  logic        s_busy, s_done, s_valid, s_last, s_rd, s_wrd;
  logic [31:0] s_in, s_w;
  int          s_row, s_col;

  always_comb begin
    s_busy = if_a.busy; s_done = if_a.done; s_valid = if_a.operand_valid;
    s_last = if_a.last; s_rd = if_a.in_rd_en; s_wrd = if_a.w_rd_en;
    s_in = 32'(if_a.input_data); s_w = 32'(if_a.weight_data);
    s_row = int'(if_a.out_row); s_col = int'(if_a.out_col);
    if (sel == 1) begin
      s_busy = if_b.busy; s_done = if_b.done; s_valid = if_b.operand_valid;
      s_last = if_b.last; s_rd = if_b.in_rd_en; s_wrd = if_b.w_rd_en;
      s_in = if_b.input_data; s_w = if_b.weight_data;
      s_row = int'(if_b.out_row); s_col = int'(if_b.out_col);
    end else if (sel == 2) begin
      s_busy = if_c.busy; s_done = if_c.done; s_valid = if_c.operand_valid;
      s_last = if_c.last; s_rd = if_c.in_rd_en; s_wrd = if_c.w_rd_en;
      s_in = 32'(if_c.input_data); s_w = 32'(if_c.weight_data);
      s_row = int'(if_c.out_row); s_col = int'(if_c.out_col);
    end
  end

  typedef struct {
    int          row;
    int          col;
    logic [31:0] din;
    logic [31:0] dw;
  } pair_t;
  pair_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       if_a.start = v;
      1:       if_b.start = v;
      default: if_c.start = v;
    endcase
  endtask

  task automatic set_rst(input int d, input logic v);
    case (d)
      0:       rst_a = v;
      1:       rst_b = v;
      default: rst_c = v;
    endcase
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, s_busy, 0);
    chk({tag, "_done"}, s_done, 0);
    chk({tag, "_valid"}, s_valid, 0);
    chk({tag, "_last"}, s_last, 0);
    chk({tag, "_rd"}, {s_rd, s_wrd}, 0);
    chk({tag, "_data"}, {s_in, s_w}, 0);
    chk({tag, "_rowcol"}, {s_row, s_col}, 0);
  endtask

  // One sweep on instance d; abort_at > 0 asserts rst at that relative cycle.
  task automatic run_sweep(input int d, input int mm, input int oo, input int win,
                           input int mid_start, input int abort_at);
    int t0, rel, pstart, nlast, nvalid, nrd, tdone, period, exp_done;
    bit first, pv, pl, new_pair;
    logic [31:0] cur_in, cur_w;
    pair_t e;
    sel    = d;
    period = PF ? win : win + 2;
    exp_done = PF ? mm * oo * win + 3 : mm * oo * (win + 2) + 1;
    for (int r = 0; r < mm; r++)
      for (int c = 0; c < oo; c++)
        exp_q.push_back('{r, c, exp_in(d, r), exp_w(d, c)});
    @(negedge clk);
    t0 = cyc;
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    tdone = -1; nlast = 0; nvalid = 0; nrd = 0; pstart = 0;
    first = 1'b1; pv = 1'b0; pl = 1'b0; cur_in = '0; cur_w = '0;
    for (int k = 0; k < mm * oo * (win + 2) + 20; k++) begin
      rel = cyc - t0;
      if (mid_start > 0 && rel == mid_start) set_start(d, 1'b1);
      if (mid_start > 0 && rel == mid_start + 1) set_start(d, 1'b0);
      if (abort_at > 0 && rel == abort_at) begin
        set_rst(d, 1'b1);
        @(negedge clk);
        chk_idle_outputs("abort");
        set_rst(d, 1'b0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", {s_done, s_busy}, 0);
        end
        exp_q.delete();
        return;
      end
      if (rel == 1) chk("fetch_strobe", {s_rd, s_wrd}, 2'b11);
      if (rel == 2) chk("load_no_strobe", {s_rd, s_wrd}, 2'b00);
      if (s_rd) nrd++;
      if (s_valid) nvalid++;
      new_pair = s_valid && (!pv || pl);
      if (new_pair) begin
        if (exp_q.size() == 0) chk("extra_pair", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pair_row", s_row, e.row);
          chk("pair_col", s_col, e.col);
          chk("pair_input", s_in, e.din);
          chk("pair_weight", s_w, e.dw);
        end
        if (first) chk("first_valid_lat", rel, 3);
        else       chk("pair_period", cyc - pstart, period);
        first  = 1'b0;
        pstart = cyc;
        cur_in = s_in;
        cur_w  = s_w;
      end
      if (s_last) begin
        nlast++;
        chk("last_pos", cyc - pstart, win - 1);
        chk("hold_input", s_in, cur_in);
        chk("hold_weight", s_w, cur_w);
      end
      if (s_done) begin
        tdone = rel;
        if (d == 0) set_start(d, 1'b1);
        break;
      end
      pv = s_valid;
      pl = s_last;
      @(negedge clk);
    end
    chk("done_lat", tdone, exp_done);
    @(negedge clk);
    chk("after_done_idle", {s_busy, s_done, s_valid}, 0);
    set_start(d, 1'b0);
    chk("last_count", nlast, mm * oo);
    chk("valid_cycles", nvalid, mm * oo * win);
    chk("read_count", nrd, mm * oo);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("start_at_done_ignored", s_busy, 0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    set_start(0, 1'b0); set_start(1, 1'b0); set_start(2, 1'b0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk_idle_outputs("reset");
    end

    run_sweep(0, 1, 1, 4, 0, 0);
    run_sweep(2, 2, 2, 4, 0, 0);
    run_sweep(1, 4, 4, 256, 500, 0);
    run_sweep(1, 4, 4, 256, 0, 3 + 6 * (PF ? 256 : 258) + 10);
    run_sweep(1, 4, 4, 256, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
